// File: rtl/eth_tx_rmii_framer.sv
// ---------------------------------------------------------------------------
// eth_tx_rmii_framer
//   Last transmit stage before the RMII PHY pins. Accepts a frame byte
//   stream (destination MAC through payload) over a valid/ready/last
//   handshake and drives RMII dibits: preamble + SFD, the frame bytes,
//   zero padding up to pMIN_FRAME, and the IEEE 802.3 CRC32 FCS. An
//   inter-packet gap is enforced after every frame or aborted frame.
//   One byte takes 4 clocks (100 Mb/s at the 50 MHz RMII clock).
//
// Ports
//   Clk           50 MHz RMII reference clock
//   Rst           synchronous, active-high reset
//   In_Dat        frame byte, first byte = destination MAC[47:40]
//   In_Valid      In_Dat valid; in IDLE it requests a frame start
//   In_Last       In_Dat is the final byte before pad/FCS
//   In_Ready      one-cycle pulse, byte taken when In_Valid & In_Ready
//   Txd           RMII TXD[1:0], Txd[0] is the earlier bit on the wire
//   Tx_En         RMII TX_EN
//   Tx_Busy       high in every state except IDLE
//   Frame_Done    one-cycle pulse the cycle after the last FCS dibit
//   Underrun_Err  one-cycle pulse when a frame is aborted for lack of data
// ---------------------------------------------------------------------------
module eth_tx_rmii_framer #(
    parameter int pMIN_FRAME = 60,
    parameter bit pPAD_EN    = 1'b1,
    parameter int pIPG_BYTES = 12
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [7:0] In_Dat,
    input  logic       In_Valid,
    input  logic       In_Last,
    output logic       In_Ready,
    output logic [1:0] Txd,
    output logic       Tx_En,
    output logic       Tx_Busy,
    output logic       Frame_Done,
    output logic       Underrun_Err
);

    localparam logic [31:0] CRC_POLY = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;
    localparam logic [10:0] MIN_CNT  = 11'(pMIN_FRAME);
    // The IDLE cycle that follows the gap also has Tx_En low, so the gap
    // state itself lasts one clock less than the full gap.
    localparam logic [15:0] IPG_LAST = 16'(pIPG_BYTES * 4 - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_SFD,
        S_DATA,
        S_PAD,
        S_FCS,
        S_IPG
    } state_t;

    state_t      state;
    logic [1:0]  dc;          // dibit index of the dibit currently on Txd
    logic [2:0]  pre_cnt;
    logic [3:0]  fcs_idx;
    logic [15:0] ipg_cnt;
    logic [10:0] byte_cnt;
    logic [31:0] crc;
    logic        last_flag;
    logic [7:0]  shreg;

    // Reflected CRC32 advanced by one dibit, Txd[0] first.
    function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 2; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ CRC_POLY;
            else             r = r >> 1;
        end
        return r;
    endfunction

    logic [31:0] crc_next;
    logic [10:0] byte_cnt_inc;
    logic [31:0] fcs_word;
    logic [3:0]  fcs_nx;

    // CRC always folds in the dibit that is on the wire this cycle.
    assign crc_next     = crc_dibit(crc, Txd);
    assign byte_cnt_inc = (byte_cnt == 11'h7FF) ? byte_cnt : byte_cnt + 11'd1;
    assign fcs_word     = ~crc;
    assign fcs_nx       = fcs_idx + 4'd1;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state        <= S_IDLE;
            dc           <= 2'd0;
            pre_cnt      <= 3'd0;
            fcs_idx      <= 4'd0;
            ipg_cnt      <= 16'd0;
            byte_cnt     <= 11'd0;
            crc          <= CRC_INIT;
            last_flag    <= 1'b0;
            In_Ready     <= 1'b0;
            Txd          <= 2'b00;
            Tx_En        <= 1'b0;
            Tx_Busy      <= 1'b0;
            Frame_Done   <= 1'b0;
            Underrun_Err <= 1'b0;
        end else begin
            In_Ready     <= 1'b0;
            Frame_Done   <= 1'b0;
            Underrun_Err <= 1'b0;

            if (In_Ready) begin
                // Byte fetch slot: last dibit of SFD or of a non-last data byte.
                if (state == S_DATA) begin
                    crc      <= crc_next;
                    byte_cnt <= byte_cnt_inc;
                end
                if (In_Valid) begin
                    state     <= S_DATA;
                    dc        <= 2'd0;
                    shreg     <= In_Dat;
                    Txd       <= In_Dat[1:0];
                    last_flag <= In_Last;
                end else begin
                    state        <= S_IPG;
                    Tx_En        <= 1'b0;
                    Txd          <= 2'b00;
                    Underrun_Err <= 1'b1;
                    ipg_cnt      <= 16'd0;
                end
            end else begin
                case (state)
                    S_IDLE: begin
                        Txd   <= 2'b00;
                        Tx_En <= 1'b0;
                        if (In_Valid) begin
                            state     <= S_PREAMBLE;
                            Tx_En     <= 1'b1;
                            Tx_Busy   <= 1'b1;
                            Txd       <= 2'b01;
                            dc        <= 2'd0;
                            pre_cnt   <= 3'd0;
                            crc       <= CRC_INIT;
                            byte_cnt  <= 11'd0;
                            last_flag <= 1'b0;
                        end
                    end

                    S_PREAMBLE: begin
                        Txd <= 2'b01;
                        dc  <= dc + 2'd1;
                        if (dc == 2'd3) begin
                            if (pre_cnt == 3'd6) begin
                                state   <= S_SFD;
                                pre_cnt <= 3'd0;
                            end else begin
                                pre_cnt <= pre_cnt + 3'd1;
                            end
                        end
                    end

                    S_SFD: begin
                        dc <= dc + 2'd1;
                        if (dc == 2'd2) begin
                            Txd      <= 2'b11;
                            In_Ready <= 1'b1;
                        end else begin
                            Txd <= 2'b01;
                        end
                    end

                    S_DATA: begin
                        crc <= crc_next;
                        dc  <= dc + 2'd1;
                        if (dc == 2'd3) begin
                            // Only the flagged last byte ends here without a fetch.
                            byte_cnt <= byte_cnt_inc;
                            if (!pPAD_EN || byte_cnt_inc >= MIN_CNT) begin
                                state   <= S_FCS;
                                fcs_idx <= 4'd0;
                                Txd     <= ~crc_next[1:0];
                            end else begin
                                state <= S_PAD;
                                Txd   <= 2'b00;
                            end
                        end else begin
                            Txd   <= shreg[3:2];
                            shreg <= shreg >> 2;
                            if (dc == 2'd2 && !last_flag) In_Ready <= 1'b1;
                        end
                    end

                    S_PAD: begin
                        crc <= crc_next;
                        dc  <= dc + 2'd1;
                        Txd <= 2'b00;
                        if (dc == 2'd3) begin
                            byte_cnt <= byte_cnt_inc;
                            if (byte_cnt_inc >= MIN_CNT) begin
                                state   <= S_FCS;
                                fcs_idx <= 4'd0;
                                Txd     <= ~crc_next[1:0];
                            end
                        end
                    end

                    S_FCS: begin
                        // CRC is frozen here; fcs_word is shifted out LSB first.
                        fcs_idx <= fcs_nx;
                        if (fcs_idx == 4'd15) begin
                            state      <= S_IPG;
                            Tx_En      <= 1'b0;
                            Txd        <= 2'b00;
                            Frame_Done <= 1'b1;
                            ipg_cnt    <= 16'd0;
                        end else begin
                            Txd <= fcs_word[{fcs_nx, 1'b0} +: 2];
                        end
                    end

                    S_IPG: begin
                        Tx_En   <= 1'b0;
                        Txd     <= 2'b00;
                        ipg_cnt <= ipg_cnt + 16'd1;
                        if (ipg_cnt >= IPG_LAST) begin
                            state    <= S_IDLE;
                            Tx_Busy  <= 1'b0;
                            crc      <= CRC_INIT;
                            byte_cnt <= 11'd0;
                            dc       <= 2'd0;
                        end
                    end

                    default: begin
                        state   <= S_IDLE;
                        Tx_En   <= 1'b0;
                        Tx_Busy <= 1'b0;
                        Txd     <= 2'b00;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_eth_tx_rmii_framer.sv
// ---------------------------------------------------------------------------
// tb_eth_tx_rmii_framer
//   Two framers (padding on / padding off) share one input stream. Each
//   frame issued pushes the expected wire image per instance into a queue;
//   a monitor per instance rebuilds bytes from the dibits and compares at
//   the end of every Tx_En burst, including the gap before the burst.
// ---------------------------------------------------------------------------
module tb_eth_tx_rmii_framer;

    localparam int K_DONE  = 0;
    localparam int K_UNDER = 1;
    localparam int K_RESET = 2;

    typedef struct {
        int         len;
        int         kind;
        int         gap;
        logic [7:0] b[256];
    } rec_t;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic [7:0] In_Dat = 8'h00;
    logic       In_Valid = 1'b0;
    logic       In_Last = 1'b0;

    logic       rdy0, en0, busy0, fd0, ue0;
    logic [1:0] txd0;
    logic       rdy1, en1, busy1, fd1, ue1;
    logic [1:0] txd1;

    int checks = 0;
    int errors = 0;
    int n_done = 0;
    int n_under = 0;
    int cnt_fd0 = 0, cnt_fd1 = 0, cnt_ue0 = 0, cnt_ue1 = 0;

    rec_t       q0[$];
    rec_t       q1[$];
    logic [7:0] pl[256];

    always #10 Clk = ~Clk;

    eth_tx_rmii_framer #(.pMIN_FRAME(60), .pPAD_EN(1'b1), .pIPG_BYTES(12)) u_pad (
        .Clk(Clk), .Rst(Rst), .In_Dat(In_Dat), .In_Valid(In_Valid), .In_Last(In_Last),
        .In_Ready(rdy0), .Txd(txd0), .Tx_En(en0), .Tx_Busy(busy0),
        .Frame_Done(fd0), .Underrun_Err(ue0));

    eth_tx_rmii_framer #(.pMIN_FRAME(60), .pPAD_EN(1'b0), .pIPG_BYTES(12)) u_nopad (
        .Clk(Clk), .Rst(Rst), .In_Dat(In_Dat), .In_Valid(In_Valid), .In_Last(In_Last),
        .In_Ready(rdy1), .Txd(txd1), .Tx_En(en1), .Tx_Busy(busy1),
        .Frame_Done(fd1), .Underrun_Err(ue1));

    always @(negedge Clk) begin
        if (fd0) cnt_fd0++;
        if (fd1) cnt_fd1++;
        if (ue0) cnt_ue0++;
        if (ue1) cnt_ue1++;
    end

    // Reference model ------------------------------------------------------
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] v);
        logic [31:0] r;
        r = c ^ {24'h0, v};
        for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    function automatic rec_t build(input int n, input int kind, input int cut,
                                   input bit pad, input int gap);
        rec_t        r;
        logic [31:0] c;
        logic [31:0] f;
        int          nb;
        r.kind = kind;
        r.gap  = gap;
        r.len  = -1;
        for (int j = 0; j < 256; j++) r.b[j] = 8'h00;
        if (kind == K_RESET) return r;
        for (int j = 0; j < 7; j++) r.b[j] = 8'h55;
        r.b[7] = 8'hD5;
        nb = (kind == K_UNDER) ? cut : n;
        for (int j = 0; j < nb; j++) r.b[8 + j] = pl[j];
        if (kind == K_UNDER) begin
            r.len = 8 + nb;
            return r;
        end
        if (pad && nb < 60) nb = 60;
        c = 32'hFFFFFFFF;
        for (int j = 0; j < nb; j++) c = crc_byte(c, r.b[8 + j]);
        f = ~c;
        for (int k = 0; k < 4; k++) r.b[8 + nb + k] = f[8*k +: 8];
        r.len = 8 + nb + 4;
        return r;
    endfunction

    // Monitor / scoreboard -------------------------------------------------
    task automatic monitor(input int which);
        logic [1:0] d[1024];
        int         nd;
        int         low;
        int         bad;
        bit         prev;
        bit         have;
        rec_t       r;
        logic [7:0] gb;
        logic       en, fd, ue, busy;
        logic [1:0] txd;
        logic [2:0] exp_f;
        nd = 0; low = 0; prev = 1'b0;
        forever begin
            @(negedge Clk);
            if (which == 0) begin en = en0; txd = txd0; fd = fd0; ue = ue0; busy = busy0; end
            else            begin en = en1; txd = txd1; fd = fd1; ue = ue1; busy = busy1; end
            if (en) begin
                if (!prev) begin
                    nd = 0;
                    have = (which == 0) ? (q0.size() != 0) : (q1.size() != 0);
                    if (!have) begin
                        checks++; errors++;
                        $display("FAIL dut%0d frame_start: unexpected burst", which);
                    end else begin
                        if (which == 0) r = q0[0]; else r = q1[0];
                        if (r.gap >= 0) begin
                            checks++;
                            if (low != r.gap) begin
                                errors++;
                                $display("FAIL dut%0d ipg: got %0d low clocks, want %0d", which, low, r.gap);
                            end
                        end
                    end
                end
                if (nd < 1024) d[nd] = txd;
                nd++;
            end else begin
                if (prev) begin
                    low = 1;
                    have = (which == 0) ? (q0.size() != 0) : (q1.size() != 0);
                    if (!have) begin
                        checks++; errors++;
                        $display("FAIL dut%0d frame_end: no expected frame", which);
                    end else begin
                        if (which == 0) r = q0.pop_front(); else r = q1.pop_front();
                        exp_f = (r.kind == K_DONE) ? 3'b101 : (r.kind == K_UNDER) ? 3'b011 : 3'b000;
                        checks++;
                        if ({fd, ue, busy} !== exp_f) begin
                            errors++;
                            $display("FAIL dut%0d end_flags {done,underrun,busy}: got %b want %b",
                                     which, {fd, ue, busy}, exp_f);
                        end
                        if (r.len >= 0) begin
                            checks++;
                            if (nd != 4 * r.len) begin
                                errors++;
                                $display("FAIL dut%0d tx_en_len: got %0d clocks want %0d", which, nd, 4 * r.len);
                            end
                            checks++;
                            bad = -1;
                            for (int j = 0; j < r.len && 4*j + 3 < nd; j++) begin
                                gb = {d[4*j+3], d[4*j+2], d[4*j+1], d[4*j]};
                                if (bad < 0 && gb !== r.b[j]) bad = j;
                            end
                            if (bad >= 0) begin
                                errors++;
                                $display("FAIL dut%0d wire_byte[%0d]: got %h want %h", which, bad,
                                         {d[4*bad+3], d[4*bad+2], d[4*bad+1], d[4*bad]}, r.b[bad]);
                            end
                        end
                    end
                end else begin
                    low++;
                end
            end
            prev = en;
        end
    endtask

    // Driver ---------------------------------------------------------------
    task automatic fail_stop(input string what);
        errors++;
        $display("FAIL %s: timeout waiting on DUT", what);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge Clk);
        while (!rdy0) begin
            n++;
            if (n > 3000) fail_stop("in_ready");
            @(negedge Clk);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge Clk);
        while (busy0 || busy1) begin
            n++;
            if (n > 5000) fail_stop("tx_busy");
            @(negedge Clk);
        end
    endtask

    task automatic send_frame(input int n, input int mode, input int cut,
                              input bit hold, input int gap, input bit golden);
        rec_t r0, r1;
        int   i;
        bit   stop;
        r0 = build(n, mode, cut, 1'b1, gap);
        r1 = build(n, mode, cut, 1'b0, gap);
        if (golden) begin
            r1.b[r1.len - 4] = 8'h26;
            r1.b[r1.len - 3] = 8'h39;
            r1.b[r1.len - 2] = 8'hF4;
            r1.b[r1.len - 1] = 8'hCB;
        end
        q0.push_back(r0);
        q1.push_back(r1);
        if (mode == K_DONE)  n_done++;
        if (mode == K_UNDER) n_under++;
        In_Valid = 1'b1;
        In_Dat   = pl[0];
        In_Last  = (n == 1);
        i = 0;
        stop = 1'b0;
        while (!stop) begin
            wait_ready();
            @(posedge Clk);
            #1;
            i++;
            if ((mode == K_DONE && i == n) || (mode != K_DONE && i == cut)) begin
                stop = 1'b1;
            end else begin
                In_Dat  = pl[i];
                In_Last = (i == n - 1);
            end
        end
        if (mode == K_UNDER) begin
            In_Valid = 1'b0;
            In_Last  = 1'b0;
            wait_ready();
            @(posedge Clk);
            #1;
        end else if (mode == K_RESET) begin
            repeat (2) @(posedge Clk);
            #1;
            Rst = 1'b1;
            In_Valid = 1'b0;
            In_Last  = 1'b0;
            @(posedge Clk);
            #1;
            Rst = 1'b0;
            checks++;
            if ({en0, busy0, en1, busy1} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_mid_frame {en0,busy0,en1,busy1}: got %b want 0000",
                         {en0, busy0, en1, busy1});
            end
        end
        if (!hold) begin
            In_Valid = 1'b0;
            In_Last  = 1'b0;
            wait_idle();
            repeat (2) @(negedge Clk);
        end
    endtask

    task automatic fill_random(input int n);
        for (int j = 0; j < n; j++) pl[j] = 8'($urandom);
    endtask

    initial begin
        int n, m, mode, cut;
        bit h, ph;

        fork
            monitor(0);
            monitor(1);
        join_none

        repeat (3) @(posedge Clk);
        @(negedge Clk);
        checks++;
        if ({rdy0, txd0, en0, busy0, fd0, ue0} !== 7'b0) begin
            errors++;
            $display("FAIL reset_state dut0: got %b want 0", {rdy0, txd0, en0, busy0, fd0, ue0});
        end
        checks++;
        if ({rdy1, txd1, en1, busy1, fd1, ue1} !== 7'b0) begin
            errors++;
            $display("FAIL reset_state dut1: got %b want 0", {rdy1, txd1, en1, busy1, fd1, ue1});
        end
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        repeat (2) @(negedge Clk);

        // 60-byte counting frame
        for (int j = 0; j < 60; j++) pl[j] = 8'(j);
        send_frame(60, K_DONE, 0, 1'b0, -1, 1'b0);

        // short frame, padded on one instance only
        fill_random(14);
        send_frame(14, K_DONE, 0, 1'b0, -1, 1'b0);

        // "123456789" with known FCS on the non-padding instance
        for (int j = 0; j < 9; j++) pl[j] = 8'h31 + 8'(j);
        send_frame(9, K_DONE, 0, 1'b0, -1, 1'b1);

        // underrun before byte 10, then back-to-back frames with valid held
        fill_random(20);
        send_frame(20, K_UNDER, 10, 1'b1, -1, 1'b0);
        fill_random(64);
        send_frame(64, K_DONE, 0, 1'b1, 48, 1'b0);
        fill_random(70);
        send_frame(70, K_DONE, 0, 1'b0, 48, 1'b0);

        // reset mid-data, then a clean frame
        fill_random(40);
        send_frame(40, K_RESET, 5, 1'b0, -1, 1'b0);
        fill_random(30);
        send_frame(30, K_DONE, 0, 1'b0, -1, 1'b0);

        // 1-byte frame (In_Last on first byte)
        fill_random(1);
        send_frame(1, K_DONE, 0, 1'b0, -1, 1'b0);

        // randomized mix
        ph = 1'b0;
        for (int it = 0; it < 14; it++) begin
            n    = int'($urandom_range(1, 120));
            m    = int'($urandom_range(0, 9));
            mode = K_DONE;
            cut  = 0;
            if (n >= 2 && m == 0) begin
                mode = K_UNDER;
                cut  = int'($urandom_range(1, n - 1));
            end else if (n >= 2 && m == 1) begin
                mode = K_RESET;
                cut  = int'($urandom_range(1, n - 1));
            end
            h = (mode != K_RESET) && (mode == K_UNDER || n >= 60) && ($urandom_range(0, 1) == 1);
            if (it == 13) h = 1'b0;
            fill_random(n);
            send_frame(n, mode, cut, h, ph ? 48 : -1, 1'b0);
            ph = h;
        end

        wait_idle();
        repeat (5) @(negedge Clk);

        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL queues_drained: got %0d/%0d pending want 0/0", q0.size(), q1.size());
        end
        checks++;
        if (cnt_fd0 != n_done || cnt_fd1 != n_done) begin
            errors++;
            $display("FAIL frame_done_count: got %0d/%0d want %0d", cnt_fd0, cnt_fd1, n_done);
        end
        checks++;
        if (cnt_ue0 != n_under || cnt_ue1 != n_under) begin
            errors++;
            $display("FAIL underrun_count: got %0d/%0d want %0d", cnt_ue0, cnt_ue1, n_under);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
